pipe_ctrl: RTL and testbench
============================

PIPE_CTRL -- requirements
Module: pipe_ctrl

Interface
REQ-001 SHALL have ports: clk  in  1  system clock, single clock domain, rising edge.
REQ-002 SHALL have ports: rst  in  1  synchronous, active-high reset.
REQ-003 SHALL have ports: load_use  in  1  ID-stage instruction needs the result of a load in EX.
REQ-004 SHALL have ports: branch_taken  in  1  branch or jump resolved taken in EX.
REQ-005 SHALL have ports: mem_req  in  1  MEM-stage instruction accesses data memory.
REQ-006 SHALL have ports: mem_done  in  1  data memory completes the access this cycle.
REQ-007 SHALL have ports: halt_mem  in  1  HALT instruction is in MEM.
REQ-008 SHALL have ports: pc_en, ifid_en, idex_en, exmem_en, memwb_en  out  1 each  write enables for PC and pipeline registers.
REQ-009 SHALL have ports: ifid_flush, idex_flush, exmem_flush, memwb_flush  out  1 each  bubble insert (control fields zeroed) into the next register.
REQ-010 SHALL have ports: halted  out  1  core stopped.
REQ-011 SHALL have ports: err  out  1  memory watchdog expired.
REQ-012 SHALL have parameter WD_MAX, default 255, meaning max MEM_WAIT cycles before err.

Function
REQ-013 SHALL hold a registered FSM with states RUN, MEM_WAIT, DRAIN, HALTED; outputs decode combinationally from state and inputs.
REQ-014 RUN defaults: all *_en=1, all *_flush=0.
REQ-015 Priority, highest first: rst, halted/err, memory stall, halt_mem, branch_taken, load_use.
REQ-016 RUN, mem_req=1, mem_done=0: same cycle pc/ifid/idex/exmem_en=0, memwb_en=1, memwb_flush=1; next state MEM_WAIT; watchdog counter loads 1.
REQ-017 RUN, mem_req=1, mem_done=1: no stall; RUN defaults apply.
REQ-018 MEM_WAIT: same outputs as REQ-016 while mem_done=0; counter increments each cycle, saturating at WD_MAX.
REQ-019 MEM_WAIT, mem_done=1: RUN defaults that cycle; next state RUN; counter clears.
REQ-020 MEM_WAIT, counter==WD_MAX, mem_done=0: next state HALTED with err=1.
REQ-021 halt_mem=1, no memory stall: pc_en=0, ifid_flush=1, idex_flush=1, exmem_flush=1, memwb_en=1; next state DRAIN.
REQ-022 DRAIN lasts exactly 1 cycle (HALT writes through MEM/WB): pc/ifid/idex/exmem_en=0, memwb_en=1, memwb_flush=1; next HALTED.
REQ-023 HALTED: all *_en=0, all *_flush=0, halted=1; left only by rst; all inputs ignored.
REQ-024 branch_taken in RUN: pc_en=1, ifid_flush=1, idex_flush=1, all en=1; load_use same cycle ignored.
REQ-025 load_use in RUN without branch: pc_en=0, ifid_en=0, idex_flush=1, others en=1 (one bubble per asserted cycle).
REQ-026 halt_mem together with memory stall: stall wins; halt is acted on when the stall releases and halt_mem is still high.
REQ-027 halted and err SHALL be registered outputs.

Reset
REQ-028 While rst=1: all *_en=0, all *_flush=1, halted=0, err=0.
REQ-029 rst=1 at a clock edge SHALL put state to RUN and clear the counter, from any state, including mid-MEM_WAIT and HALTED.

Configuration
REQ-030 Macro PIPE_CTRL_PERF_EN defined: add output stall_cycles out 16, incremented in every cycle where pc_en=0 and state!=HALTED; wraps 0xFFFF->0; cleared by rst.
REQ-031 Macro PIPE_CTRL_PERF_EN undefined: no stall_cycles port and no counter logic; all other behaviour identical.

Verification
REQ-032 Load-use: RUN, load_use=1 for 1 cycle -> pc_en=0, ifid_en=0, idex_flush=1 that cycle; defaults next cycle.
REQ-033 Branch+load_use: both=1 -> ifid_flush=1, idex_flush=1, pc_en=1.
REQ-034 Mem stall: mem_req=1, mem_done low 3 cycles then high -> exmem_en=0 and memwb_flush=1 for 3 cycles, RUN defaults on 4th; stall_cycles=3 with PERF_EN.
REQ-035 Watchdog: WD_MAX=4, mem_done never high -> err=1, halted=1 after 5 stall cycles; rst -> err=0, RUN.
REQ-036 Halt: halt_mem=1 -> flushes that cycle, DRAIN 1 cycle, then halted=1, all en=0; later branch_taken=1 has no effect.

Source files
------------

// File: rtl/pipe_ctrl.sv
// pipe_ctrl: pipeline hazard / stall / halt controller for a 5-stage core.
// Generates write enables and bubble-insert flushes for the PC and the
// IF/ID, ID/EX, EX/MEM and MEM/WB registers. A watchdog bounds how long a
// data-memory access may stall the pipe before the core is stopped with err.
// Optional feature: define PIPE_CTRL_PERF_EN to add a 16-bit stall_cycles
// performance counter output.
module pipe_ctrl #(
  parameter int WD_MAX = 255
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        load_use,
  input  logic        branch_taken,
  input  logic        mem_req,
  input  logic        mem_done,
  input  logic        halt_mem,
  output logic        pc_en,
  output logic        ifid_en,
  output logic        idex_en,
  output logic        exmem_en,
  output logic        memwb_en,
  output logic        ifid_flush,
  output logic        idex_flush,
  output logic        exmem_flush,
  output logic        memwb_flush,
  output logic        halted,
`ifdef PIPE_CTRL_PERF_EN
  output logic [15:0] stall_cycles,
`endif
  output logic        err
);

  localparam int CW = $clog2(WD_MAX + 1);

  typedef enum logic [1:0] {RUN, MEM_WAIT, DRAIN, HALTED} state_t;

  state_t          state, next_state;
  logic [CW-1:0]   wd_cnt;
  logic            wd_expire;
  logic            halted_q, err_q;
  logic            mem_stall;

  // An access that has not completed this cycle freezes everything up to MEM.
  assign mem_stall = mem_req & ~mem_done;

  // State register; reset is synchronous and wins from any state.
  // NOTE: sequential state uses non-blocking (<=) so every flop samples the
  // pre-edge values of its inputs, independent of statement order.
  always_ff @(posedge clk) begin
    if (rst) state <= RUN;
    else     state <= next_state;
  end

  // Next-state logic; wd_expire flags the watchdog giving up on memory.
  // NOTE: every always_comb target gets a default first, so no path leaves it
  // unassigned and no latch is inferred.
  always_comb begin
    next_state = state;
    wd_expire  = 1'b0;
    case (state)
      RUN: begin
        if (mem_stall)     next_state = MEM_WAIT;
        else if (halt_mem) next_state = DRAIN;
      end
      MEM_WAIT: begin
        if (mem_done) next_state = RUN;
        else if (wd_cnt == CW'(WD_MAX)) begin
          next_state = HALTED;
          wd_expire  = 1'b1;
        end
      end
      DRAIN:   next_state = HALTED;
      default: next_state = HALTED;
    endcase
  end

  // Watchdog counter: loads 1 on stall entry, counts waiting cycles,
  // saturates at WD_MAX, clears whenever the pipe is not waiting on memory.
  always_ff @(posedge clk) begin
    if (rst) begin
      wd_cnt <= '0;
    end else if (state == RUN && mem_stall) begin
      wd_cnt <= CW'(1);
    end else if (state == MEM_WAIT && !mem_done) begin
      if (wd_cnt != CW'(WD_MAX)) wd_cnt <= wd_cnt + CW'(1);
    end else begin
      wd_cnt <= '0;
    end
  end

  // Registered status: halted follows entry into HALTED, err is sticky.
  always_ff @(posedge clk) begin
    if (rst) begin
      halted_q <= 1'b0;
      err_q    <= 1'b0;
    end else begin
      halted_q <= (next_state == HALTED);
      err_q    <= err_q | wd_expire;
    end
  end

  assign halted = halted_q;
  assign err    = err_q;

  // Output decode from state and inputs, highest priority first.
  always_comb begin
    pc_en       = 1'b1;
    ifid_en     = 1'b1;
    idex_en     = 1'b1;
    exmem_en    = 1'b1;
    memwb_en    = 1'b1;
    ifid_flush  = 1'b0;
    idex_flush  = 1'b0;
    exmem_flush = 1'b0;
    memwb_flush = 1'b0;
    if (rst) begin
      {pc_en, ifid_en, idex_en, exmem_en, memwb_en} = '0;
      {ifid_flush, idex_flush, exmem_flush, memwb_flush} = '1;
    end else begin
      case (state)
        HALTED: begin
          {pc_en, ifid_en, idex_en, exmem_en, memwb_en} = '0;
        end
        DRAIN: begin
          {pc_en, ifid_en, idex_en, exmem_en} = '0;
          memwb_flush = 1'b1;
        end
        MEM_WAIT: begin
          // The release cycle (mem_done=1) runs with plain defaults.
          if (!mem_done) begin
            {pc_en, ifid_en, idex_en, exmem_en} = '0;
            memwb_flush = 1'b1;
          end
        end
        default: begin
          if (mem_stall) begin
            {pc_en, ifid_en, idex_en, exmem_en} = '0;
            memwb_flush = 1'b1;
          end else if (halt_mem) begin
            pc_en       = 1'b0;
            ifid_flush  = 1'b1;
            idex_flush  = 1'b1;
            exmem_flush = 1'b1;
          end else if (branch_taken) begin
            ifid_flush = 1'b1;
            idex_flush = 1'b1;
          end else if (load_use) begin
            pc_en      = 1'b0;
            ifid_en    = 1'b0;
            idex_flush = 1'b1;
          end
        end
      endcase
    end
  end

`ifdef PIPE_CTRL_PERF_EN
  // Counts every cycle the PC is frozen while the core is still alive.
  always_ff @(posedge clk) begin
    if (rst)                               stall_cycles <= '0;
    else if (!pc_en && state != HALTED)    stall_cycles <= stall_cycles + 16'd1;
  end
`endif

endmodule

// File: tb/tb_pipe_ctrl.sv
// tb_pipe_ctrl: directed scenarios followed by randomized traffic, every
// cycle compared against a flag-based reference model of the controller.
module tb_pipe_ctrl;

  localparam int WD = 4;

  logic clk = 1'b0;
  logic rst, load_use, branch_taken, mem_req, mem_done, halt_mem;
  logic pc_en, ifid_en, idex_en, exmem_en, memwb_en;
  logic ifid_flush, idex_flush, exmem_flush, memwb_flush;
  logic halted, err;
`ifdef PIPE_CTRL_PERF_EN
  logic [15:0] stall_cycles;
`endif

  int errors = 0;
  int checks = 0;

  // Reference model state: plain flags and a wait-cycle count.
  bit m_halt, m_err, m_drain;
  int m_wait;      // 0 = not waiting, else number of waiting cycles so far
  int m_stalls;    // modelled perf counter

  always #5 clk = ~clk;

  pipe_ctrl #(.WD_MAX(WD)) dut (
    .clk(clk), .rst(rst), .load_use(load_use), .branch_taken(branch_taken),
    .mem_req(mem_req), .mem_done(mem_done), .halt_mem(halt_mem),
    .pc_en(pc_en), .ifid_en(ifid_en), .idex_en(idex_en), .exmem_en(exmem_en),
    .memwb_en(memwb_en), .ifid_flush(ifid_flush), .idex_flush(idex_flush),
    .exmem_flush(exmem_flush), .memwb_flush(memwb_flush), .halted(halted),
`ifdef PIPE_CTRL_PERF_EN
    .stall_cycles(stall_cycles),
`endif
    .err(err)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Expected {pc,ifid,idex,exmem,memwb en, ifid,idex,exmem,memwb flush, halted, err}.
  function automatic logic [10:0] model_out(input logic r, lu, br, mr, md, hm);
    logic [4:0] en;
    logic [3:0] fl;
    bit waiting;
    en = 5'b11111;
    fl = 4'b0000;
    waiting = (m_wait > 0);
    if (r) begin
      en = 5'b00000; fl = 4'b1111;
    end else if (m_halt) begin
      en = 5'b00000;
    end else if (m_drain || (waiting ? !md : (mr && !md))) begin
      en = 5'b00001; fl = 4'b0001;
    end else if (waiting) begin
      en = 5'b11111;
    end else if (hm) begin
      en = 5'b01111; fl = 4'b1110;
    end else if (br) begin
      fl = 4'b1100;
    end else if (lu) begin
      en = 5'b00111; fl = 4'b0100;
    end
    return {en, fl, m_halt, m_err};
  endfunction

  function automatic logic [10:0] dut_out();
    return {pc_en, ifid_en, idex_en, exmem_en, memwb_en,
            ifid_flush, idex_flush, exmem_flush, memwb_flush, halted, err};
  endfunction

  // Advance the model across one clock edge.
  task automatic model_step(input logic r, lu, br, mr, md, hm);
    logic [10:0] o;
    o = model_out(r, lu, br, mr, md, hm);
    if (r) begin
      m_stalls = 0;
    end else if (!o[10] && !m_halt) begin
      m_stalls = (m_stalls + 1) % 65536;
    end
    if (r) begin
      m_halt = 0; m_err = 0; m_drain = 0; m_wait = 0;
    end else if (m_halt) begin
      // stays stopped
    end else if (m_drain) begin
      m_drain = 0; m_halt = 1;
    end else if (m_wait > 0) begin
      if (md)                m_wait = 0;
      else if (m_wait == WD) begin m_halt = 1; m_err = 1; m_wait = 0; end
      else                   m_wait++;
    end else if (mr && !md) begin
      m_wait = 1;
    end else if (hm) begin
      m_drain = 1;
    end
  endtask

  // One cycle: drive at negedge, check mid-low-phase, clock, update model.
  task automatic step(input string tag, input logic r, lu, br, mr, md, hm);
    rst = r; load_use = lu; branch_taken = br;
    mem_req = mr; mem_done = md; halt_mem = hm;
    #1;
    check(tag, 32'(dut_out()), 32'(model_out(r, lu, br, mr, md, hm)));
`ifdef PIPE_CTRL_PERF_EN
    check({tag, "_perf"}, 32'(stall_cycles), 32'(m_stalls));
`endif
    @(posedge clk);
    model_step(r, lu, br, mr, md, hm);
    @(negedge clk);
  endtask

  initial begin
    rst = 1'b1; load_use = 0; branch_taken = 0; mem_req = 0; mem_done = 0; halt_mem = 0;
    @(posedge clk);
    m_halt = 0; m_err = 0; m_drain = 0; m_wait = 0; m_stalls = 0;
    @(negedge clk);

    // Reset state
    step("reset", 1, 0, 0, 0, 0, 0);
    step("run_idle", 0, 0, 0, 0, 0, 0);

    // Load-use bubble, then defaults
    step("load_use", 0, 1, 0, 0, 0, 0);
    step("after_lu", 0, 0, 0, 0, 0, 0);

    // Branch beats load-use
    step("br_lu", 0, 1, 1, 0, 0, 0);
    step("mem_hit", 0, 0, 0, 1, 1, 0);

    // Memory stall 3 cycles, release on 4th
    step("rst_perf", 1, 0, 0, 0, 0, 0);
    step("mstall0", 0, 0, 0, 1, 0, 0);
    step("mstall1", 0, 1, 1, 1, 0, 1);
    step("mstall2", 0, 0, 0, 1, 0, 0);
    #1 check("exmem_en_stall", 32'(exmem_en), 32'd0);
    check("memwb_flush_stall", 32'(memwb_flush), 32'd1);
    step("mrelease", 0, 0, 0, 1, 1, 0);
`ifdef PIPE_CTRL_PERF_EN
    #1 check("stall_cycles_3", 32'(stall_cycles), 32'd3);
`endif
    step("post_rel", 0, 0, 0, 0, 0, 0);

    // Watchdog expiry after WD+1 stall cycles
    for (int i = 0; i < WD + 1; i++) step("wd_stall", 0, 0, 0, 1, 0, 0);
    #1 check("wd_err", 32'(err), 32'd1);
    check("wd_halted", 32'(halted), 32'd1);
    step("wd_ignored", 0, 1, 1, 1, 1, 1);
    step("wd_rst", 1, 0, 0, 0, 0, 0);
    #1 check("wd_err_clear", 32'(err), 32'd0);
    step("wd_run", 0, 0, 0, 0, 0, 0);

    // Halt: flush, drain, halted; branch ignored afterwards
    step("halt", 0, 0, 0, 0, 0, 1);
    step("drain", 0, 0, 1, 0, 0, 0);
    #1 check("halted_set", 32'(halted), 32'd1);
    step("halted_br", 0, 0, 1, 0, 0, 0);
    step("halted_rst", 1, 0, 0, 0, 0, 0);

    // Randomized traffic
    for (int n = 0; n < 3000; n++) begin
      logic r, lu, br, mr, md, hm;
      r  = ($urandom_range(0, 199) == 0) || (m_halt && $urandom_range(0, 7) == 0);
      lu = ($urandom_range(0, 3) == 0);
      br = ($urandom_range(0, 4) == 0);
      mr = ($urandom_range(0, 1) == 0);
      md = (m_wait > 0) ? ($urandom_range(0, 2) == 0) : ($urandom_range(0, 1) == 0);
      hm = ($urandom_range(0, 49) == 0);
      step("random", r, lu, br, mr, md, hm);
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  // Guard against a stalled run.
  initial begin
    #2000000;
    $display("FAIL timeout observed=running expected=finished");
    $fatal(1, "timeout");
  end

endmodule
